// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bundle: the pipeline-side status the unit watches and the
// enables, flushes, forwarding selects and counters it produces.
// The pipeline drives through `master`; the hazard unit uses `slave`.
interface pipeline_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int COUNT_W = 32
);
  logic [REG_AW-1:0]  id_rs, id_rt;
  logic               id_rs_used, id_rt_used;
  logic [REG_AW-1:0]  ex_rs, ex_rt;
  logic               ex_rs_used, ex_rt_used;
  logic [REG_AW-1:0]  ex_wreg;
  logic               ex_regwrite, ex_memtoreg;
  logic [REG_AW-1:0]  mem_wreg, wb_wreg;
  logic               mem_regwrite, wb_regwrite;
  logic               mem_access;
  logic               branch_taken, jump;
  logic               wb_valid;

  logic               pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic               if_id_flush, id_ex_flush;
  logic [1:0]         fwd_a, fwd_b;
  logic               fwd_id_a, fwd_id_b;
  logic [COUNT_W-1:0] count_all, count_branch, count_jmp, count_stall;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used,
           ex_rs, ex_rt, ex_rs_used, ex_rt_used,
           ex_wreg, ex_regwrite, ex_memtoreg,
           mem_wreg, wb_wreg, mem_regwrite, wb_regwrite,
           mem_access, branch_taken, jump, wb_valid,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, fwd_a, fwd_b, fwd_id_a, fwd_id_b,
           count_all, count_branch, count_jmp, count_stall
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used,
           ex_rs, ex_rt, ex_rs_used, ex_rt_used,
           ex_wreg, ex_regwrite, ex_memtoreg,
           mem_wreg, wb_wreg, mem_regwrite, wb_regwrite,
           mem_access, branch_taken, jump, wb_valid,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, fwd_a, fwd_b, fwd_id_a, fwd_id_b,
           count_all, count_branch, count_jmp, count_stall
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and performance-count controller for the 5-stage
// MIPS pipeline. Generates stage enables/flushes, EX and ID forwarding
// selects, a multi-cycle memory freeze (MEM_LAT > 1) and four saturating
// counters. clr is a synchronous active-low reset.
// Optional feature macro: HAZARD_FWD_EN. Defined = operand forwarding with
// load-use stalls only; undefined = no forwarding, full RAW interlock.
module pipeline_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int COUNT_W = 32,
  parameter int MEM_LAT = 1
) (
  input logic                   clk,
  input logic                   clr,
  pipeline_hazard_unit_if.slave hz
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // A producer hazards a source when it writes a non-zero register that
  // the consumer actually reads.
  function automatic logic match(input logic [REG_AW-1:0] src,
                                 input logic              used,
                                 input logic [REG_AW-1:0] dst,
                                 input logic              we);
    return we && used && (dst != '0) && (dst == src);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic               en);
    return (en && (v != '1)) ? v + COUNT_W'(1) : v;
  endfunction

  logic hold;
  logic redirect;
  logic raw_stall;
  logic stall_eff;

  logic id_dep_ex, id_dep_mem, id_dep_wb;

  assign redirect = hz.branch_taken || hz.jump;

  assign id_dep_ex  = match(hz.id_rs, hz.id_rs_used, hz.ex_wreg, hz.ex_regwrite) ||
                      match(hz.id_rt, hz.id_rt_used, hz.ex_wreg, hz.ex_regwrite);
  assign id_dep_mem = match(hz.id_rs, hz.id_rs_used, hz.mem_wreg, hz.mem_regwrite) ||
                      match(hz.id_rt, hz.id_rt_used, hz.mem_wreg, hz.mem_regwrite);
  assign id_dep_wb  = match(hz.id_rs, hz.id_rs_used, hz.wb_wreg, hz.wb_regwrite) ||
                      match(hz.id_rt, hz.id_rt_used, hz.wb_wreg, hz.wb_regwrite);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign raw_stall = hz.ex_memtoreg && id_dep_ex;
`else
  // Without bypassing the consumer waits until the producer has left WB.
  assign raw_stall = id_dep_ex || id_dep_mem || id_dep_wb;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{hz.ex_rs, hz.ex_rt, hz.ex_rs_used, hz.ex_rt_used,
                               hz.ex_memtoreg};
`endif

  generate
    if (MEM_LAT > 1) begin : g_freeze
      state_t     state;
      logic [3:0] cnt;

      // An access holds the pipe from its first MEM cycle until cnt runs out.
      always_comb hold = ((state == S_IDLE) && hz.mem_access) ||
                         ((state == S_WAIT) && (cnt != 4'd0));

      // Freeze FSM: arm the down-counter on a new access, release at zero.
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      always_ff @(posedge clk) begin
        if (!clr) begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end else begin
          case (state)
            S_IDLE: if (hz.mem_access) begin
              state <= S_WAIT;
              cnt   <= 4'(MEM_LAT - 2);
            end
            S_WAIT: if (cnt != 4'd0) cnt   <= cnt - 4'd1;
                    else             state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end
      end
    end else begin : g_no_freeze
      logic unused_mem_access;
      assign unused_mem_access = hz.mem_access;
      assign hold = 1'b0;
    end
  endgenerate

  // Enable/flush priority: reset > hold > redirect > RAW stall > run.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    hz.pc_en       = 1'b1;
    hz.if_id_en    = 1'b1;
    hz.id_ex_en    = 1'b1;
    hz.ex_mem_en   = 1'b1;
    hz.mem_wb_en   = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    stall_eff      = 1'b0;
    if (!clr) begin
      hz.pc_en       = 1'b0;
      hz.if_id_en    = 1'b0;
      hz.id_ex_en    = 1'b0;
      hz.ex_mem_en   = 1'b0;
      hz.mem_wb_en   = 1'b0;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (hold) begin
      hz.pc_en     = 1'b0;
      hz.if_id_en  = 1'b0;
      hz.id_ex_en  = 1'b0;
      hz.ex_mem_en = 1'b0;
      hz.mem_wb_en = 1'b0;
    end else if (redirect) begin
      // The ID instruction is squashed, so any pending stall is moot.
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (raw_stall) begin
      hz.pc_en       = 1'b0;
      hz.if_id_en    = 1'b0;
      hz.id_ex_flush = 1'b1;
      stall_eff      = 1'b1;
    end
  end

  // Forwarding selects: the younger MEM producer wins over WB.
  always_comb begin
    hz.fwd_a    = 2'b00;
    hz.fwd_b    = 2'b00;
    hz.fwd_id_a = 1'b0;
    hz.fwd_id_b = 1'b0;
`ifdef HAZARD_FWD_EN
    if (clr) begin
      if (match(hz.ex_rs, hz.ex_rs_used, hz.mem_wreg, hz.mem_regwrite))
        hz.fwd_a = 2'b01;
      else if (match(hz.ex_rs, hz.ex_rs_used, hz.wb_wreg, hz.wb_regwrite))
        hz.fwd_a = 2'b10;
      if (match(hz.ex_rt, hz.ex_rt_used, hz.mem_wreg, hz.mem_regwrite))
        hz.fwd_b = 2'b01;
      else if (match(hz.ex_rt, hz.ex_rt_used, hz.wb_wreg, hz.wb_regwrite))
        hz.fwd_b = 2'b10;
      hz.fwd_id_a = match(hz.id_rs, hz.id_rs_used, hz.wb_wreg, hz.wb_regwrite);
      hz.fwd_id_b = match(hz.id_rt, hz.id_rt_used, hz.wb_wreg, hz.wb_regwrite);
    end
`endif
  end

  logic [COUNT_W-1:0] cnt_all, cnt_branch, cnt_jmp, cnt_stall;

  // Saturating performance counters; events during a freeze are not counted
  // because the frozen instruction is re-evaluated on the release cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_all    <= '0;
      cnt_branch <= '0;
      cnt_jmp    <= '0;
      cnt_stall  <= '0;
    end else begin
      cnt_all    <= sat_inc(cnt_all,    hz.wb_valid     && !hold);
      cnt_branch <= sat_inc(cnt_branch, hz.branch_taken && !hold);
      cnt_jmp    <= sat_inc(cnt_jmp,    hz.jump         && !hold);
      cnt_stall  <= sat_inc(cnt_stall,  hold || stall_eff);
    end
  end

  assign hz.count_all    = cnt_all;
  assign hz.count_branch = cnt_branch;
  assign hz.count_jmp    = cnt_jmp;
  assign hz.count_stall  = cnt_stall;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit (MEM_LAT = 3, COUNT_W = 4).
// Directed scenarios followed by randomized cycles, all compared against a
// rule-level reference model. Works with HAZARD_FWD_EN defined or not.
module tb_pipeline_hazard_unit;
  localparam int REG_AW  = 5;
  localparam int COUNT_W = 4;
  localparam int MEM_LAT = 3;
  localparam int CMAX    = (1 << COUNT_W) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_AW(REG_AW), .COUNT_W(COUNT_W)) hz ();

  pipeline_hazard_unit #(
    .REG_AW (REG_AW),
    .COUNT_W(COUNT_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .clr(clr),
    .hz (hz)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: counters as plain integers, freeze tracked as
  // the number of cycles the current access has already spent in MEM.
  int m_all, m_br, m_jmp, m_stall, m_age;
  logic       e_hold, e_redirect, e_raw;
  logic [4:0] e_en;
  logic [1:0] e_fl, e_fa, e_fb, e_fid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic dep(input logic [REG_AW-1:0] src, input logic used,
                               input logic [REG_AW-1:0] dst, input logic we);
    return we && used && (int'(dst) != 0) && (src == dst);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic idle();
    clr = 1'b1;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_rs_used = 0; hz.id_rt_used = 0;
    hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_rs_used = 0; hz.ex_rt_used = 0;
    hz.ex_wreg = '0; hz.ex_regwrite = 0; hz.ex_memtoreg = 0;
    hz.mem_wreg = '0; hz.wb_wreg = '0; hz.mem_regwrite = 0; hz.wb_regwrite = 0;
    hz.mem_access = 0; hz.branch_taken = 0; hz.jump = 0; hz.wb_valid = 0;
  endtask

  task automatic model_eval();
    logic on_ex, on_mem, on_wb;
    on_ex  = dep(hz.id_rs, hz.id_rs_used, hz.ex_wreg, hz.ex_regwrite) ||
             dep(hz.id_rt, hz.id_rt_used, hz.ex_wreg, hz.ex_regwrite);
    on_mem = dep(hz.id_rs, hz.id_rs_used, hz.mem_wreg, hz.mem_regwrite) ||
             dep(hz.id_rt, hz.id_rt_used, hz.mem_wreg, hz.mem_regwrite);
    on_wb  = dep(hz.id_rs, hz.id_rs_used, hz.wb_wreg, hz.wb_regwrite) ||
             dep(hz.id_rt, hz.id_rt_used, hz.wb_wreg, hz.wb_regwrite);
    // An access occupies MEM for MEM_LAT cycles; all but the last are holds.
    e_hold     = (m_age == 0) ? (hz.mem_access && MEM_LAT > 1) : (m_age < MEM_LAT - 1);
    e_redirect = hz.branch_taken || hz.jump;
    e_raw      = FWD_ON ? (hz.ex_memtoreg && on_ex) : (on_ex || on_mem || on_wb);
    if (!clr)            begin e_en = 5'b00000; e_fl = 2'b11; end
    else if (e_hold)     begin e_en = 5'b00000; e_fl = 2'b00; end
    else if (e_redirect) begin e_en = 5'b11111; e_fl = 2'b11; end
    else if (e_raw)      begin e_en = 5'b00111; e_fl = 2'b01; end
    else                 begin e_en = 5'b11111; e_fl = 2'b00; end
    e_fa = 2'd0; e_fb = 2'd0; e_fid = 2'd0;
    if (FWD_ON && clr) begin
      if (dep(hz.ex_rs, hz.ex_rs_used, hz.mem_wreg, hz.mem_regwrite))     e_fa = 2'd1;
      else if (dep(hz.ex_rs, hz.ex_rs_used, hz.wb_wreg, hz.wb_regwrite))  e_fa = 2'd2;
      if (dep(hz.ex_rt, hz.ex_rt_used, hz.mem_wreg, hz.mem_regwrite))     e_fb = 2'd1;
      else if (dep(hz.ex_rt, hz.ex_rt_used, hz.wb_wreg, hz.wb_regwrite))  e_fb = 2'd2;
      e_fid = {dep(hz.id_rs, hz.id_rs_used, hz.wb_wreg, hz.wb_regwrite),
               dep(hz.id_rt, hz.id_rt_used, hz.wb_wreg, hz.wb_regwrite)};
    end
  endtask

  task automatic model_update();
    if (!clr) begin
      m_all = 0; m_br = 0; m_jmp = 0; m_stall = 0; m_age = 0;
    end else begin
      if (hz.wb_valid && !e_hold)     m_all = sat(m_all + 1);
      if (hz.branch_taken && !e_hold) m_br  = sat(m_br + 1);
      if (hz.jump && !e_hold)         m_jmp = sat(m_jmp + 1);
      if (e_hold || (!e_redirect && e_raw)) m_stall = sat(m_stall + 1);
      if (m_age == 0) m_age = e_hold ? 1 : 0;
      else            m_age = (m_age < MEM_LAT - 1) ? m_age + 1 : 0;
    end
  endtask

  // Inputs are applied 1 time unit after the edge; outputs are compared
  // 2 units later, well clear of the next rising edge.
  task automatic settle();
    #2;
    model_eval();
    check("enables", {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, e_en);
    check("flushes", {hz.if_id_flush, hz.id_ex_flush}, e_fl);
    check("fwd_a", hz.fwd_a, e_fa);
    check("fwd_b", hz.fwd_b, e_fb);
    check("fwd_id", {hz.fwd_id_a, hz.fwd_id_b}, e_fid);
    check("count_all", hz.count_all, m_all);
    check("count_branch", hz.count_branch, m_br);
    check("count_jmp", hz.count_jmp, m_jmp);
    check("count_stall", hz.count_stall, m_stall);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  initial begin
    int base;
    idle();
    clr = 1'b0;
    m_all = 0; m_br = 0; m_jmp = 0; m_stall = 0; m_age = 0;
    @(posedge clk);
    #1;

    // Reset state: everything disabled and flushed, counters zero.
    settle();
    check("rst_en", {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, 5'b00000);
    check("rst_flush", {hz.if_id_flush, hz.id_ex_flush}, 2'b11);
    check("rst_count_stall", hz.count_stall, 0);
    advance();

    // lw $8 in EX, add $9,$8,$8 in ID.
    idle();
    hz.ex_wreg = 5'd8; hz.ex_regwrite = 1; hz.ex_memtoreg = 1;
    hz.id_rs = 5'd8; hz.id_rt = 5'd8; hz.id_rs_used = 1; hz.id_rt_used = 1;
    settle();
    check("lu_pc_en", hz.pc_en, 1'b0);
    check("lu_if_id_en", hz.if_id_en, 1'b0);
    check("lu_id_ex_flush", hz.id_ex_flush, 1'b1);
    advance();
    idle();
    hz.mem_wreg = 5'd8; hz.mem_regwrite = 1;
    hz.id_rs = 5'd8; hz.id_rt = 5'd8; hz.id_rs_used = 1; hz.id_rt_used = 1;
    settle();
    check("lu_count_stall", hz.count_stall, 1);
    advance();
    idle();
    hz.wb_wreg = 5'd8; hz.wb_regwrite = 1; hz.wb_valid = 1;
    hz.ex_rs = 5'd8; hz.ex_rt = 5'd8; hz.ex_rs_used = 1; hz.ex_rt_used = 1;
    hz.ex_wreg = 5'd9; hz.ex_regwrite = 1;
    settle();
    check("lu_fwd_a", hz.fwd_a, FWD_ON ? 2'b10 : 2'b00);
    check("lu_fwd_b", hz.fwd_b, FWD_ON ? 2'b10 : 2'b00);
    advance();

    // add $1 in MEM, sub $2,$1,$3 in EX.
    idle();
    hz.mem_wreg = 5'd1; hz.mem_regwrite = 1;
    hz.ex_rs = 5'd1; hz.ex_rt = 5'd3; hz.ex_rs_used = 1; hz.ex_rt_used = 1;
    settle();
    check("as_fwd_a", hz.fwd_a, FWD_ON ? 2'b01 : 2'b00);
    check("as_fwd_b", hz.fwd_b, 2'b00);
    check("as_pc_en", hz.pc_en, 1'b1);
    advance();

    // $0 as destination never forwards.
    idle();
    hz.mem_wreg = 5'd0; hz.mem_regwrite = 1; hz.wb_wreg = 5'd0; hz.wb_regwrite = 1;
    hz.ex_rs = 5'd0; hz.ex_rt = 5'd0; hz.ex_rs_used = 1; hz.ex_rt_used = 1;
    settle();
    check("zero_fwd", {hz.fwd_a, hz.fwd_b}, 4'b0000);
    advance();

    // Taken beq coinciding with a load-use condition.
    idle();
    base = m_br;
    hz.ex_wreg = 5'd8; hz.ex_regwrite = 1; hz.ex_memtoreg = 1;
    hz.id_rs = 5'd8; hz.id_rs_used = 1; hz.branch_taken = 1;
    settle();
    check("br_flush", {hz.if_id_flush, hz.id_ex_flush}, 2'b11);
    check("br_pc_en", hz.pc_en, 1'b1);
    advance();
    idle();
    settle();
    check("br_count", hz.count_branch, base + 1);
    advance();

    // Two back-to-back stores with MEM_LAT = 3.
    idle();
    base = m_stall;
    hz.mem_access = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("sw_pc_en", hz.pc_en, (i % 3) == 2);
      advance();
    end
    idle();
    settle();
    check("sw_count_stall", hz.count_stall, sat(base + 4));
    advance();

    // add $1 then add $2,$1,$1 walking down the pipe.
    idle();
    base = m_stall;
    for (int i = 0; i < 4; i++) begin
      idle();
      hz.id_rs = 5'd1; hz.id_rt = 5'd1; hz.id_rs_used = 1; hz.id_rt_used = 1;
      if (i == 0) begin hz.ex_wreg  = 5'd1; hz.ex_regwrite  = 1; end
      if (i == 1) begin hz.mem_wreg = 5'd1; hz.mem_regwrite = 1; end
      if (i == 2) begin hz.wb_wreg  = 5'd1; hz.wb_regwrite  = 1; end
      settle();
      check("dep_fwd_ab", {hz.fwd_a, hz.fwd_b}, 4'b0000);
      advance();
    end
    idle();
    settle();
    check("dep_count_stall", hz.count_stall, sat(base + (FWD_ON ? 0 : 3)));
    advance();

    // Reset while the freeze FSM is in WAIT.
    idle();
    hz.mem_access = 1; hz.wb_valid = 1;
    cycle();
    clr = 1'b0;
    settle();
    check("rw_en", {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, 5'b00000);
    advance();
    idle();
    settle();
    check("rw_en_after", {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, 5'b11111);
    check("rw_counts", {hz.count_all, hz.count_stall}, 8'h00);
    advance();

    // Saturation: 20 retirements into a 4-bit counter.
    idle();
    hz.wb_valid = 1;
    for (int i = 0; i < 20; i++) cycle();
    idle();
    settle();
    check("sat_count_all", hz.count_all, CMAX);
    advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      clr             = ($urandom_range(0, 39) != 0);
      hz.id_rs        = REG_AW'($urandom_range(0, 3));
      hz.id_rt        = REG_AW'($urandom_range(0, 3));
      hz.id_rs_used   = 1'($urandom_range(0, 1));
      hz.id_rt_used   = 1'($urandom_range(0, 1));
      hz.ex_rs        = REG_AW'($urandom_range(0, 3));
      hz.ex_rt        = REG_AW'($urandom_range(0, 3));
      hz.ex_rs_used   = 1'($urandom_range(0, 1));
      hz.ex_rt_used   = 1'($urandom_range(0, 1));
      hz.ex_wreg      = REG_AW'($urandom_range(0, 3));
      hz.ex_regwrite  = 1'($urandom_range(0, 1));
      hz.ex_memtoreg  = 1'($urandom_range(0, 1));
      hz.mem_wreg     = REG_AW'($urandom_range(0, 3));
      hz.wb_wreg      = REG_AW'($urandom_range(0, 3));
      hz.mem_regwrite = 1'($urandom_range(0, 1));
      hz.wb_regwrite  = 1'($urandom_range(0, 1));
      hz.mem_access   = ($urandom_range(0, 5) == 0);
      hz.branch_taken = ($urandom_range(0, 7) == 0);
      hz.jump         = ($urandom_range(0, 7) == 0);
      hz.wb_valid     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard, forwarding and performance-count controller for the 5-stage MIPS pipeline. It turns the ideal (hazard-free) pipeline into one that runs arbitrary code. It sits beside the IF_ID/ID_EX/EX_MEM/MEM_WB registers and generates:
- PC and stage enables, stage flushes and forwarding selects;
- a multi-cycle memory wait freeze;
- saturating instruction, branch, jump and stall counters that replace the ad-hoc Count_* outputs.

## Interface
Parameters:
- REG_AW, 5, register-address width
- COUNT_W, 32, width of each performance counter
- MEM_LAT, 1, cycles a memory access occupies the MEM stage (1..16); 1 = single-cycle RAM, no freeze

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- clr  input  1  synchronous, active-low reset
- id_rs, id_rt  input  REG_AW  source registers of the instruction in ID
- id_rs_used, id_rt_used  input  1  source actually read (R1_used/R2_used)
- ex_rs, ex_rt  input  REG_AW  sources of the instruction in EX
- ex_rs_used, ex_rt_used  input  1  EX source used
- ex_wreg  input  REG_AW  destination in EX
- ex_regwrite, ex_memtoreg  input  1  EX writes a register / is a load
- mem_wreg, wb_wreg  input  REG_AW  destinations in MEM / WB
- mem_regwrite, wb_regwrite  input  1  MEM / WB write a register
- mem_access  input  1  instruction in MEM is a load or store
- branch_taken, jump  input  1  EX resolved taken branch / jmp, jal or jr
- wb_valid  input  1  a non-bubble instruction retires this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1  register enables
- if_id_flush, id_ex_flush  output  1  insert bubble (active high)
- fwd_a, fwd_b  output  2  EX ALU operand select: 00 ID_EX value, 01 EX_MEM Result1, 10 WB Din
- fwd_id_a, fwd_id_b  output  1  ID operand takes WB Din (regfile write-through)
- count_all, count_branch, count_jmp, count_stall  output  COUNT_W  performance counters

## Operation
- "match(r, p)" means the producer writes, has destination != 0, and the destination equals r with that source used.
- **Forwarding (combinational).**
  - fwd_a = 01 if match(ex_rs, mem), else 10 if match(ex_rs, wb), else 00. fwd_b is the same using ex_rt.
  - fwd_id_a = match(id_rs, wb). fwd_id_b is the same using id_rt.
- **Load-use stall.**
  - Condition: ex_memtoreg and match(id_rs or id_rt, ex).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1; other enables stay 1.
  - Lasts exactly one cycle per occurrence.
- **Redirect.**
  - Condition: branch_taken or jump.
  - Response: if_id_flush = 1, id_ex_flush = 1, pc_en = 1.
  - Redirect overrides the load-use stall, because the ID instruction is squashed anyway.
- **Memory freeze FSM** (states IDLE, WAIT; 4-bit down-counter cnt). Present only if MEM_LAT > 1.
  - IDLE and mem_access: hold = 1, cnt <= MEM_LAT-2, go to WAIT.
  - WAIT and cnt != 0: hold = 1, cnt decrements.
  - WAIT and cnt == 0: hold = 0, go to IDLE; the access completes and advances.
  - Result: MEM_LAT-1 hold cycles per access, including back-to-back accesses.
- **Hold effect.**
  - All five enables = 0 and both flushes = 0.
  - The frozen branch/stall condition is re-evaluated on the release cycle.
- **Priority:** hold > redirect > load-use > run (all enables 1, flushes 0).
- **Counters.**
  - All four saturate at 2^COUNT_W-1; none wraps.
  - count_all increments when wb_valid and not hold.
  - count_branch increments when branch_taken and not hold.
  - count_jmp increments when jump and not hold.
  - count_stall increments on every hold or load-use stall cycle.

## Timing
- Enables, flushes and forwarding selects are combinational from same-cycle inputs and FSM state.
- Counters and FSM update on the rising clk edge; a counter is visible one cycle after its event.
- Reset (clr = 0 at an edge) puts the FSM in IDLE, cnt = 0 and all counters = 0.
- While clr = 0:
  - all enables = 0 and both flushes = 1;
  - fwd_a and fwd_b = 00, fwd_id_a and fwd_id_b = 0.
- Reset in WAIT aborts the access; the FSM is in IDLE on the first cycle after clr returns to 1.
- clr has priority over every event in the same cycle.

## Configuration
- HAZARD_FWD_EN defined: forwarding operates as above; RAW stalls occur only for load-use.
- Undefined:
  - fwd_a, fwd_b, fwd_id_a and fwd_id_b are tied to 0.
  - An interlock stall (same response as load-use) is raised while match(id_rs or id_rt, ex, mem or wb).
  - A dependent ALU instruction therefore stalls 3 cycles.
  - Redirect, freeze and counters are unchanged.

## Test plan
- lw $8 in EX, add $9,$8,$8 in ID, forwarding on:
  - 1 cycle pc_en = 0, if_id_en = 0, id_ex_flush = 1, count_stall 0 -> 1;
  - next cycle fwd_a = fwd_b = 10.
- add $1 followed by sub $2,$1,$3: fwd_a = 01, fwd_b = 00, no stall.
- $0 as destination: no forwarding.
- beq taken in EX coinciding with a load-use condition:
  - if_id_flush = id_ex_flush = 1, pc_en = 1, no stall;
  - count_branch +1 next cycle.
- MEM_LAT = 3, two consecutive sw:
  - pattern hold, hold, release, hold, hold, release (all enables 0 during holds);
  - count_stall = 4.
- COUNT_W = 4, wb_valid high 20 cycles: count_all stops at 15.
- clr = 0 during WAIT: counters 0, FSM in IDLE, enables resume 1 after release.
- HAZARD_FWD_EN undefined, add $1 then add $2,$1,$1: exactly 3 stall cycles, fwd_a = fwd_b = 00 throughout.
